// File: rtl/mc_ctrl_pkg.sv
// Shared MIPS multi-cycle control encodings:
// states, instruction classes, opcodes, functs, mux codes.
package mips_defs;

  typedef enum logic [3:0] {
    S_FETCH, S_DCD, S_EXE, S_MEMRD, S_MEMWR,
    S_WBALU, S_WBMEM, S_BR, S_JMP, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_ORI, C_LUI, C_LW, C_SW,
    C_BEQ, C_J, C_JAL, C_JR, C_BAD
  } iclass_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_JMP = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl and the datapath:
// IR fields and zero in, enables and selects out.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic       IRWr;
  logic [2:0] npcSel;
  logic       RegWr;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic [2:0] ALUOp;
  logic       ExtOp;
  logic       MemWr;
  logic [1:0] MemToReg;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output PCWr, IRWr, npcSel, RegWr, RegDst,
    output ALUSrc, ALUOp, ExtOp, MemWr,
    output MemToReg, illegal
  );

  modport slave (
    output op, funct, zero,
    input  PCWr, IRWr, npcSel, RegWr, RegDst,
    input  ALUSrc, ALUOp, ExtOp, MemWr,
    input  MemToReg, illegal
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// op/funct to instruction class; anything
// unrecognised maps to C_BAD.
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  logic is_r;
  assign is_r = (op == OP_R);

  // classify the latched instruction
  always_comb begin
    cls = C_BAD;
    unique case (1'b1)
      is_r && (funct == FN_ADDU ||
               funct == FN_SUBU): cls = C_RTYPE;
      is_r && funct == FN_JR:     cls = C_JR;
      op == OP_ORI:               cls = C_ORI;
      op == OP_LUI:               cls = C_LUI;
      op == OP_LW:                cls = C_LW;
      op == OP_SW:                cls = C_SW;
      op == OP_BEQ:               cls = C_BEQ;
      op == OP_J:                 cls = C_J;
      op == OP_JAL:               cls = C_JAL;
      default:                    cls = C_BAD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (fetch..write-back).
// MC_CTRL_ILLEGAL_TRAP_EN: bad opcodes halt until reset.
module mc_ctrl
  import mips_defs::*;
(
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  state_t  state;
  state_t  nxt;
  iclass_t cls;

  logic pcwr, irwr, regwr, memwr;

  mc_decode u_dec (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls)
  );

  // state register, forced to FETCH by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= nxt;
  end

  // next state and Moore output decode
  always_comb begin
    nxt          = S_FETCH;
    pcwr         = 1'b0;
    irwr         = 1'b0;
    regwr        = 1'b0;
    memwr        = 1'b0;
    bus.npcSel   = NPC_PC4;
    bus.RegDst   = DST_RT;
    bus.ALUSrc   = 1'b0;
    bus.ALUOp    = ALU_ADD;
    bus.ExtOp    = 1'b0;
    bus.MemToReg = M2R_ALU;
    case (state)
      S_FETCH: begin
        irwr = 1'b1;
        pcwr = 1'b1;
        nxt  = S_DCD;
      end
      S_DCD: begin
        case (cls)
          C_RTYPE, C_ORI, C_LUI,
          C_LW, C_SW:      nxt = S_EXE;
          C_BEQ:           nxt = S_BR;
          C_J, C_JAL, C_JR: nxt = S_JMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:         nxt = S_HALT;
`else
          default:         nxt = S_FETCH;
`endif
        endcase
      end
      S_EXE: begin
        bus.ALUSrc = (cls != C_RTYPE);
        bus.ExtOp  = (cls == C_LW) || (cls == C_SW);
        case (cls)
          C_RTYPE: bus.ALUOp = (bus.funct == FN_SUBU)
                               ? ALU_SUB : ALU_ADD;
          C_ORI:   bus.ALUOp = ALU_OR;
          C_LUI:   bus.ALUOp = ALU_LUI;
          default: bus.ALUOp = ALU_ADD;
        endcase
        case (cls)
          C_LW:    nxt = S_MEMRD;
          C_SW:    nxt = S_MEMWR;
          default: nxt = S_WBALU;
        endcase
      end
      S_WBALU: begin
        regwr      = 1'b1;
        bus.RegDst = (cls == C_RTYPE) ? DST_RD : DST_RT;
      end
      S_MEMRD: nxt = S_WBMEM;
      S_WBMEM: begin
        regwr        = 1'b1;
        bus.MemToReg = M2R_MEM;
      end
      S_MEMWR: memwr = 1'b1;
      S_BR: begin
        bus.ALUOp  = ALU_SUB;
        bus.npcSel = NPC_BEQ;
        pcwr       = bus.zero;
      end
      S_JMP: begin
        pcwr = 1'b1;
        if (cls == C_JR) begin
          bus.npcSel = NPC_JR;
        end else begin
          bus.npcSel = NPC_JMP;
        end
        if (cls == C_JAL) begin
          regwr        = 1'b1;
          bus.RegDst   = DST_RA;
          bus.MemToReg = M2R_PC4;
        end
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_HALT: nxt = S_HALT;
`endif
      default: nxt = S_FETCH;
    endcase
  end

  // write enables are held off while in reset
  assign bus.PCWr  = pcwr  & rst;
  assign bus.IRWr  = irwr  & rst;
  assign bus.RegWr = regwr & rst;
  assign bus.MemWr = memwr & rst;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal = (state == S_HALT);
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction
// expected cycle tables against random instruction mix.
module tb_mc_ctrl;

  localparam int K_ADDU = 0;
  localparam int K_SUBU = 1;
  localparam int K_ORI  = 2;
  localparam int K_LUI  = 3;
  localparam int K_LW   = 4;
  localparam int K_SW   = 5;
  localparam int K_BEQ  = 6;
  localparam int K_J    = 7;
  localparam int K_JAL  = 8;
  localparam int K_JR   = 9;
  localparam int K_BAD  = 10;

  typedef struct packed {
    logic        br;
    logic [16:0] v;
  } step_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  step_t      exp_q[$];
  logic [5:0] cur_op;
  logic [5:0] cur_fn;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWr,IRWr,npcSel,RegWr,RegDst,ALUSrc,
  //  ALUOp,ExtOp,MemWr,MemToReg,illegal}
  function automatic logic [16:0] mk(
    input logic pc, input logic ir,
    input logic [2:0] npc, input logic rw,
    input logic [1:0] rd, input logic as,
    input logic [2:0] ao, input logic eo,
    input logic mw, input logic [1:0] mr,
    input logic il);
    return {pc, ir, npc, rw, rd, as,
            ao, eo, mw, mr, il};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.PCWr, bus.IRWr, bus.npcSel,
            bus.RegWr, bus.RegDst, bus.ALUSrc,
            bus.ALUOp, bus.ExtOp, bus.MemWr,
            bus.MemToReg, bus.illegal};
  endfunction

  function automatic logic [4:0] obs_en();
    return {bus.PCWr, bus.IRWr, bus.RegWr,
            bus.MemWr, bus.illegal};
  endfunction

  function automatic logic legal_op(
    input logic [5:0] o);
    return o == 6'h00 || o == 6'h0d ||
           o == 6'h0f || o == 6'h23 ||
           o == 6'h2b || o == 6'h04 ||
           o == 6'h02 || o == 6'h03;
  endfunction

  task automatic push(input logic br,
                      input logic [16:0] v);
    step_t s;
    s.br = br;
    s.v  = v;
    exp_q.push_back(s);
  endtask

  // Load op/funct and the expected per-cycle table
  task automatic set_kind(input int k);
    logic [16:0] f;
    logic [16:0] z;
    logic [5:0]  r;
    f = mk(1,1,0,0,0,0,0,0,0,0,0);
    z = '0;
    exp_q.delete();
    cur_fn = 6'($urandom_range(0, 63));
    push(0, f);
    push(0, z);
    case (k)
      K_ADDU: begin
        cur_op = 6'h00; cur_fn = 6'h21;
        push(0, mk(0,0,0,0,0,0,0,0,0,0,0));
        push(0, mk(0,0,0,1,1,0,0,0,0,0,0));
      end
      K_SUBU: begin
        cur_op = 6'h00; cur_fn = 6'h23;
        push(0, mk(0,0,0,0,0,0,1,0,0,0,0));
        push(0, mk(0,0,0,1,1,0,0,0,0,0,0));
      end
      K_ORI: begin
        cur_op = 6'h0d;
        push(0, mk(0,0,0,0,0,1,2,0,0,0,0));
        push(0, mk(0,0,0,1,0,0,0,0,0,0,0));
      end
      K_LUI: begin
        cur_op = 6'h0f;
        push(0, mk(0,0,0,0,0,1,3,0,0,0,0));
        push(0, mk(0,0,0,1,0,0,0,0,0,0,0));
      end
      K_LW: begin
        cur_op = 6'h23;
        push(0, mk(0,0,0,0,0,1,0,1,0,0,0));
        push(0, z);
        push(0, mk(0,0,0,1,0,0,0,0,0,1,0));
      end
      K_SW: begin
        cur_op = 6'h2b;
        push(0, mk(0,0,0,0,0,1,0,1,0,0,0));
        push(0, mk(0,0,0,0,0,0,0,0,1,0,0));
      end
      K_BEQ: begin
        cur_op = 6'h04;
        push(1, mk(0,0,1,0,0,0,1,0,0,0,0));
      end
      K_J: begin
        cur_op = 6'h02;
        push(0, mk(1,0,2,0,0,0,0,0,0,0,0));
      end
      K_JAL: begin
        cur_op = 6'h03;
        push(0, mk(1,0,2,1,2,0,0,0,0,2,0));
      end
      K_JR: begin
        cur_op = 6'h00; cur_fn = 6'h08;
        push(0, mk(1,0,3,0,0,0,0,0,0,0,0));
      end
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          cur_op = 6'h00;
          r = 6'($urandom_range(0, 63));
          while (r == 6'h21 || r == 6'h23 ||
                 r == 6'h08)
            r = 6'($urandom_range(0, 63));
          cur_fn = r;
        end else begin
          r = 6'($urandom_range(0, 63));
          while (legal_op(r))
            r = 6'($urandom_range(0, 63));
          cur_op = r;
        end
      end
    endcase
  endtask

  // Entered in the low phase of a FETCH cycle
  task automatic run_steps(input int n,
                           input string nm);
    logic [16:0] e;
    for (int i = 0; i < n && i < exp_q.size();
         i++) begin
      bus.zero = 1'($urandom_range(0, 1));
      #1;
      e = exp_q[i].v;
      if (exp_q[i].br) e[16] = bus.zero;
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL %s cyc%0d got=%h want=%h",
                 nm, i, obs(), e);
      end
      if (i == 0) begin
        bus.op    = cur_op;
        bus.funct = cur_fn;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input int k,
                           input string nm);
    set_kind(k);
    run_steps(exp_q.size(), nm);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.op    = 6'($urandom_range(0, 63));
      bus.funct = 6'($urandom_range(0, 63));
      bus.zero  = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (obs_en() !== 5'b0) begin
        bad++;
        $display("FAIL reset cyc%0d got=%b want=0",
                 i, obs_en());
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    run_instr(K_ADDU, "addu");
    run_instr(K_SUBU, "subu");
    run_instr(K_ORI,  "ori");
    run_instr(K_LUI,  "lui");
    run_instr(K_LW,   "lw");
    run_instr(K_SW,   "sw");
    for (int z = 0; z < 2; z++) begin
      set_kind(K_BEQ);
      run_steps(2, "beq");
      bus.zero = 1'(z);
      #1;
      total++;
      if (bus.PCWr !== 1'(z) ||
          bus.npcSel !== 3'd1) begin
        bad++;
        $display("FAIL beq_z%0d got=%b/%0d want=%0d/1",
                 z, bus.PCWr, bus.npcSel, z);
      end
      @(negedge clk);
    end
    run_instr(K_J,   "j");
    run_instr(K_JAL, "jal");
    run_instr(K_JR,  "jr");
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 150; n++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 9);
`else
      k = $urandom_range(0, 10);
`endif
      run_instr(k, "rand");
    end
  endtask

  task automatic test_midreset();
    set_kind(K_LW);
    run_steps(4, "mid_lw");
    #2;
    total++;
    if (bus.RegWr !== 1'b1) begin
      bad++;
      $display("FAIL mid_wbmem got=%b want=1",
               bus.RegWr);
    end
    rst = 1'b0;
    #1;
    total++;
    if (obs_en() !== 5'b0) begin
      bad++;
      $display("FAIL mid_rst got=%b want=0",
               obs_en());
    end
    @(negedge clk);
    rst = 1'b1;
    run_instr(K_ADDU, "after_rst");
    run_instr(K_BEQ,  "after_rst2");
  endtask

  task automatic test_illegal();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    set_kind(K_BAD);
    run_steps(2, "bad");
    for (int i = 0; i < 6; i++) begin
      bus.zero  = 1'($urandom_range(0, 1));
      bus.op    = 6'($urandom_range(0, 63));
      bus.funct = 6'($urandom_range(0, 63));
      #1;
      total++;
      if (obs() !== 17'h1) begin
        bad++;
        $display("FAIL halt cyc%0d got=%h want=1",
                 i, obs());
      end
      @(negedge clk);
    end
    test_reset();
    run_instr(K_SW, "post_halt");
`else
    set_kind(K_BAD);
    cur_op = 6'h3f;
    run_steps(2, "bad_nop");
    run_instr(K_JAL, "post_nop");
`endif
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    bus.op    = '0;
    bus.funct = '0;
    bus.zero  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_midreset();
    test_illegal();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS datapath. It sequences the instruction-fetch unit (PC write, IR write, next-PC select) and the rest of the datapath (register file, ALU, data memory) through the fetch, decode, execute, memory and write-back states of each instruction. It takes the latched opcode and funct from the IR plus the ALU `zero` flag, and drives every datapath write enable and mux select.

## Interface
Parameters:
- none; all encodings live in the shared package.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  6  instrR[31:26]
- funct  in  6  instrR[5:0]
- zero  in  1  ALU zero flag, valid in BR state
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- npcSel  out  3  0 = PC+4, 1 = beq target, 2 = j/jal target, 3 = jr (A)
- RegWr  out  1  register-file write
- RegDst  out  2  0 = rt, 1 = rd, 2 = $31
- ALUSrc  out  1  0 = B, 1 = extended immediate
- ALUOp  out  3  0 = add, 1 = sub, 2 = or, 3 = lui
- ExtOp  out  1  0 = zero-extend, 1 = sign-extend
- MemWr  out  1  data-memory write
- MemToReg  out  2  0 = ALU, 1 = memory, 2 = pcp4
- illegal  out  1  sticky illegal-opcode flag

## Operation
- States: FETCH, DCD, EXE, MEMRD, MEMWR, WBALU, WBMEM, BR, JMP, HALT.
- FETCH: IRWr=1, PCWr=1, npcSel=0. Next state is DCD.
- DCD is decode only. Transitions from DCD:
  - R-type addu/subu → EXE
  - ori, lui, lw, sw → EXE
  - beq → BR
  - j, jal, and R-type jr (funct 001000) → JMP
  - anything else → illegal handling (see Configuration)
- EXE: ALUSrc=0 for R-type, 1 otherwise.
  - ALUOp: add for addu/lw/sw, sub for subu, or for ori, lui for lui.
  - ExtOp=1 for lw/sw, 0 for ori/lui.
  - Next state: lw → MEMRD, sw → MEMWR, else → WBALU.
- WBALU: RegWr=1, MemToReg=0. RegDst=1 for R-type, 0 otherwise. Next state is FETCH.
- MEMRD: no writes. Next state is WBMEM.
- WBMEM: RegWr=1, MemToReg=1, RegDst=0. Next state is FETCH.
- MEMWR: MemWr=1. Next state is FETCH.
- BR: ALUOp=sub, ALUSrc=0, npcSel=1, PCWr=zero. Next state is FETCH.
- JMP: PCWr=1. Next state is FETCH.
  - j: npcSel=2.
  - jal: npcSel=2, plus RegWr=1, RegDst=2, MemToReg=2.
  - jr: npcSel=3.
- All outputs are Moore outputs decoded from the state register and the latched op/funct. The only exception is PCWr in BR, which is combinational on `zero`.
- Any output not listed for a state is 0.

## Timing
- Cycles per instruction: lw=5; R-type, ori, lui, sw=4; beq, j, jal, jr=3.
- During reset (rst low): state is forced to FETCH asynchronously, and all write enables (PCWr, IRWr, RegWr, MemWr) are forced to 0 regardless of state. illegal=0.
- The first fetch happens on the first rising edge after rst goes high.
- Reset mid-instruction: the in-flight instruction is abandoned with no partial write. After release, execution restarts in FETCH.
- op/funct are sampled from the IR every cycle. The IR is stable from DCD onward because IRWr is asserted only in FETCH.
- beq not taken: PCWr=0 in BR. The PC already holds PC+4 from FETCH, so there is no double increment.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - an unrecognised op/funct in DCD → HALT
  - HALT holds all write enables at 0 and sets illegal=1
  - HALT is left only by reset
- Macro undefined:
  - an unrecognised op/funct is a NOP: DCD → FETCH
  - illegal is tied to 0 and HALT is not implemented

## Structure
- Shared package `mips_defs` holds:
  - state encoding
  - opcode localparams: R=000000, ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011
  - funct localparams: addu=100001, subu=100011, jr=001000
  - npcSel, ALUOp, RegDst and MemToReg codes
- One sub-module, `mc_decode`: combinational op/funct → instruction class (rtype, ori, lui, lw, sw, beq, j, jal, jr, bad).
- `mc_ctrl` contains the state register, next-state logic and output decode.

## Test plan
- Reset: hold rst=0 for 3 cycles → PCWr=IRWr=RegWr=MemWr=0 and illegal=0. The first edge after release asserts IRWr=1, PCWr=1, npcSel=0.
- addu (op 000000, funct 100001) → FETCH, DCD, EXE, WBALU. In WBALU: RegWr=1, RegDst=1, MemToReg=0. Then back to FETCH; 4 cycles total.
- lw (op 100011) → MEMRD, then WBMEM with RegWr=1 and MemToReg=1; 5 cycles. sw (op 101011) → MemWr=1 for exactly 1 cycle; 4 cycles.
- beq (op 000100) with zero=1 → in BR, PCWr=1 and npcSel=1. Repeat with zero=0 → in BR, PCWr=0. Both take 3 cycles.
- jal (op 000011) → in JMP: PCWr=1, npcSel=2, RegWr=1, RegDst=2, MemToReg=2. jr (funct 001000) → npcSel=3.
- op 111111 with macro defined → HALT: illegal=1 and all write enables 0 until rst. Without the macro → returns to FETCH with illegal=0.
